// File: rtl/data_ram_ws.sv
// rtl/data_ram_ws.sv - 4-lane 32-bit word RAM with request/ack handshake and programmable wait states
module data_ram_ws #(
  parameter int DEPTH_LOG2  = 10,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        sel,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("data_ram_ws: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_sel;
  logic [31:0]       r_data;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic                  accept;
  logic                  enter_ack;
  logic                  op_we;
  logic [ADDR_W-1:0]     op_addr;
  logic [3:0]            op_sel;
  logic [31:0]           op_data;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic                  sel_bad;
  logic                  align_bad;
  logic                  range_bad;
  logic                  op_err;
  logic                  do_write;

  assign accept = ce && (state == S_IDLE || state == S_ACK);

  // With no wait states the operation happens at the acceptance edge itself,
  // so it must use the live request rather than the not-yet-latched copy.
  assign enter_ack = (WAIT_CYCLES == 0) ? accept : (state == S_WAIT && cnt == 4'd1);
  assign op_we     = (WAIT_CYCLES == 0) ? we     : r_we;
  assign op_addr   = (WAIT_CYCLES == 0) ? addr   : r_addr;
  assign op_sel    = (WAIT_CYCLES == 0) ? sel    : r_sel;
  assign op_data   = (WAIT_CYCLES == 0) ? data_i : r_data;
  assign op_idx    = op_addr[DEPTH_LOG2+1:2];

  always_comb begin
    sel_bad   = 1'b0;
    align_bad = 1'b0;
    case (op_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
      4'b0011, 4'b1100: align_bad = op_addr[0];
      4'b1111:          align_bad = (op_addr[1:0] != 2'b00);
      default:          sel_bad   = 1'b1;
    endcase
  end

  assign range_bad = |(op_addr >> (DEPTH_LOG2 + 2));
  assign op_err    = sel_bad || align_bad || range_bad;
  assign do_write  = enter_ack && op_we && !op_err && !rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (op_sel[i]) mem[op_idx][8*i +: 8] <= op_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      data_o <= 32'd0;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_sel  <= 4'd0;
      r_data <= 32'd0;
    end else begin
      ack_o <= enter_ack;
      err_o <= enter_ack && op_err;
      if (enter_ack) begin
        if (op_err)      data_o <= 32'd0;
        else if (!op_we) data_o <= mem[op_idx];
      end

      if (accept) begin
        r_we   <= we;
        r_addr <= addr;
        r_sel  <= sel;
        r_data <= data_i;
      end

      case (state)
        S_IDLE, S_ACK: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state <= S_ACK;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACK;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state == S_WAIT);

endmodule

// File: tb/tb_data_ram_ws.sv
// tb/tb_data_ram_ws.sv - self-checking bench for data_ram_ws at 0, 2 and 3 wait states
module tb_data_ram_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ce, we;
  logic [31:0] addr   [3];
  logic [3:0]  sel    [3];
  logic [31:0] data_i [3];
  logic [31:0] data_o [3];
  logic [2:0]  ack, err, busy;

  int tests = 0;
  int fails = 0;
  int wc_of [3] = '{0, 2, 3};

  logic [31:0] mdl [3][1024];
  bit          vld [3][1024];

  always #5 clk = ~clk;

  data_ram_ws #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .ce(ce[0]), .we(we[0]), .addr(addr[0]), .sel(sel[0]),
    .data_i(data_i[0]), .data_o(data_o[0]), .ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0]));
  data_ram_ws #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .ce(ce[1]), .we(we[1]), .addr(addr[1]), .sel(sel[1]),
    .data_i(data_i[1]), .data_o(data_o[1]), .ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1]));
  data_ram_ws #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .ce(ce[2]), .we(we[2]), .addr(addr[2]), .sel(sel[2]),
    .data_i(data_i[2]), .data_o(data_o[2]), .ack_o(ack[2]), .err_o(err[2]), .busy_o(busy[2]));

  function automatic bit exp_err(input logic [31:0] a, input logic [3:0] s);
    bit legal;
    legal = (s == 4'h1 || s == 4'h2 || s == 4'h4 || s == 4'h8 ||
             s == 4'h3 || s == 4'hC || s == 4'hF);
    if (!legal) return 1'b1;
    if ((s == 4'h3 || s == 4'hC) && a[0]) return 1'b1;
    if (s == 4'hF && a[1:0] != 2'b00) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_write(input int k, input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d);
    int w;
    w = int'(a[11:2]);
    mdl[k][w] = merge(vld[k][w] ? mdl[k][w] : 32'd0, d, s);
    if (s != 4'hF && !vld[k][w]) return;
    vld[k][w] = 1'b1;
  endtask

  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input string tag);
    int n, nb, wi;
    bit got, e;
    logic [31:0] prev, expd;
    n = 1; nb = 0; got = 1'b0;
    e = exp_err(a, s);
    wi = int'(a[11:2]);
    @(negedge clk);
    ce[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; data_i[k] = d;
    prev = data_o[k];
    @(negedge clk);
    ce[k] = 1'b0;
    while (n <= 20) begin
      if (ack[k]) begin
        got = 1'b1;
        break;
      end
      if (busy[k]) nb++;
      @(negedge clk);
      n++;
    end
    tests++;
    if (!got || n != wc_of[k] + 1) begin
      fails++;
      $display("FAIL %s latency: got ack=%0b at cycle %0d, required cycle %0d", tag, got, n, wc_of[k] + 1);
    end
    tests++;
    if (nb != wc_of[k]) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", tag, nb, wc_of[k]);
    end
    tests++;
    if (err[k] !== e) begin
      fails++;
      $display("FAIL %s err_o: got %0b, required %0b", tag, err[k], e);
    end
    tests++;
    if (busy[k] !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_in_ack: got %0b, required 0", tag, busy[k]);
    end
    if (w) begin
      if (!e) model_write(k, a, s, d);
      expd = e ? 32'd0 : prev;
      tests++;
      if (data_o[k] !== expd) begin
        fails++;
        $display("FAIL %s data_o_after_write: got %h, required %h", tag, data_o[k], expd);
      end
    end else if (e || vld[k][wi]) begin
      expd = e ? 32'd0 : mdl[k][wi];
      tests++;
      if (data_o[k] !== expd) begin
        fails++;
        $display("FAIL %s read_data: got %h, required %h", tag, data_o[k], expd);
      end
    end
    @(negedge clk);
    tests++;
    if (ack[k] !== 1'b0 || err[k] !== 1'b0) begin
      fails++;
      $display("FAIL %s ack_pulse_width: got ack=%0b err=%0b, required 0 0", tag, ack[k], err[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (data_o[k] !== 32'd0 || ack[k] !== 1'b0 || err[k] !== 1'b0 || busy[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state[%0d]: got data=%h ack=%0b err=%0b busy=%0b, required all 0",
                 k, data_o[k], ack[k], err[k], busy[k]);
      end
    end
  endtask

  task automatic test_basic_w2();
    txn(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "basic_wr");
    txn(1, 1'b0, 32'h10, 4'hF, 32'h0, "basic_rd");
    tests++;
    if (data_o[1] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_readback: got %h, required deadbeef", data_o[1]);
    end
  endtask

  task automatic test_byte_merge();
    txn(1, 1'b1, 32'h20, 4'hF, 32'h11223344, "merge_wr_full");
    txn(1, 1'b1, 32'h20, 4'h1, 32'h000000AA, "merge_wr_byte");
    txn(1, 1'b0, 32'h20, 4'h1, 32'h0, "merge_rd");
    tests++;
    if (data_o[1] !== 32'h112233AA) begin
      fails++;
      $display("FAIL merge_result: got %h, required 112233aa", data_o[1]);
    end
  endtask

  task automatic test_errors();
    txn(1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, "err_setup");
    txn(1, 1'b1, 32'h2, 4'hF, 32'hFFFFFFFF, "err_misaligned");
    txn(1, 1'b1, 32'h0, 4'h5, 32'hFFFFFFFF, "err_badsel");
    txn(1, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, "err_range");
    txn(1, 1'b0, 32'h1000, 4'hF, 32'h0, "err_range_rd");
    txn(1, 1'b0, 32'h0, 4'hF, 32'h0, "err_reread");
    tests++;
    if (data_o[1] !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL err_word_intact: got %h, required cafef00d", data_o[1]);
    end
  endtask

  task automatic test_stream_w0();
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i <= 4; i++) begin
        @(negedge clk);
        if (i > 0) begin
          tests++;
          if (ack[0] !== 1'b1 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
            fails++;
            $display("FAIL stream_ack[%0d.%0d]: got ack=%0b busy=%0b err=%0b, required 1 0 0",
                     pass, i - 1, ack[0], busy[0], err[0]);
          end
          if (pass == 1) begin
            tests++;
            if (data_o[0] !== d[i-1]) begin
              fails++;
              $display("FAIL stream_data[%0d]: got %h, required %h", i - 1, data_o[0], d[i-1]);
            end
          end
        end
        if (i < 4) begin
          ce[0] = 1'b1; we[0] = (pass == 0); addr[0] = 32'(i * 4); sel[0] = 4'hF; data_i[0] = d[i];
          if (pass == 0) model_write(0, 32'(i * 4), 4'hF, d[i]);
        end else begin
          ce[0] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; sel[0] = 4'hF; data_i[0] = d;
    model_write(0, 32'h14, 4'hF, d);
    @(negedge clk);
    we[0] = 1'b0; data_i[0] = 32'h0;
    @(negedge clk);
    ce[0] = 1'b0;
    tests++;
    if (ack[0] !== 1'b1 || data_o[0] !== d) begin
      fails++;
      $display("FAIL wr_then_rd: got ack=%0b data=%h, required 1 %h", ack[0], data_o[0], d);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    txn(2, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, "rstmid_setup");
    @(negedge clk);
    ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; sel[2] = 4'hF; data_i[2] = 32'h12345678;
    @(negedge clk);
    ce[2] = 1'b0;
    @(negedge clk);
    tests++;
    if (busy[2] !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_busy: got %0b, required 1", busy[2]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (data_o[2] !== 32'd0 || ack[2] !== 1'b0 || err[2] !== 1'b0 || busy[2] !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_outputs: got data=%h ack=%0b err=%0b busy=%0b, required all 0",
               data_o[2], ack[2], err[2], busy[2]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack[2]) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL rstmid_no_ack: got %0d ack pulses, required 0", pulses);
    end
    txn(2, 1'b0, 32'h40, 4'hF, 32'h0, "rstmid_reread");
  endtask

  task automatic test_random();
    logic [3:0]  sel_tab [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'hF};
    logic [31:0] a;
    logic [3:0]  s;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) txn(k, 1'b1, 32'(i * 4 + 256), 4'hF, $urandom, "rnd_init");
      for (int i = 0; i < 40; i++) begin
        a = 32'(($urandom_range(0, 15) * 4) + 256);
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(12, 31));
        s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : sel_tab[$urandom_range(0, 7)];
        txn(k, 1'($urandom), a, s, $urandom, "rnd");
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ce = '0; we = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; sel[k] = '0; data_i[k] = '0;
      for (int w = 0; w < 1024; w++) begin
        vld[k][w] = 1'b0;
        mdl[k][w] = 32'd0;
      end
    end
    test_reset();
    test_basic_w2();
    test_byte_merge();
    test_errors();
    test_stream_w0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_ram_ws.md
Name: data_ram_ws

Overview:
Next-generation data memory for the OpenMIPS SOPC simulation platform. It is a 4-byte-lane word RAM behind a registered request/acknowledge handshake. The number of wait states is programmable, and the block flags illegal byte-select patterns and out-of-range addresses. It sits between the MEM stage's bus interface and the testbench's data space, so the core's stall logic can be exercised with realistic memory latency.

Parameters:
DEPTH_LOG2, 10, log2 of word count; memory is 2^DEPTH_LOG2 words of 32 bits
ADDR_W, 32, byte-address width
WAIT_CYCLES, 1, extra cycles between request acceptance and acknowledge (0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active high
ce  input  1  request valid
we  input  1  1 = write, 0 = read
addr  input  ADDR_W  byte address; word index = addr[DEPTH_LOG2+1:2]
sel  input  4  byte-lane enables; sel[3] = bits 31:24 … sel[0] = bits 7:0
data_i  input  32  write data, lane-aligned
data_o  output  32  read data, registered
ack_o  output  1  one-cycle completion pulse
err_o  output  1  completion with error; valid only when ack_o = 1
busy_o  output  1  request in flight; new requests are not accepted

Behaviour:
- Reset (rst = 1 at the edge): state goes to IDLE; data_o = 0, ack_o = 0, err_o = 0, busy_o = 0; wait counter = 0. Memory contents are not cleared.
- States and busy_o:
  - IDLE: busy_o = 0.
  - WAIT: busy_o = 1.
  - ACK: busy_o = 0. This is the completion cycle.
- Acceptance: a request is accepted at an edge where ce = 1 and the state is IDLE or ACK. On acceptance, we, addr, sel and data_i are latched.
  - If WAIT_CYCLES = 0, the next state is ACK.
  - Otherwise the next state is WAIT and the counter is loaded with WAIT_CYCLES.
- WAIT: the counter decrements each edge. When the counter is 1 at an edge, the next state is ACK. ce is ignored in WAIT; the master holds the request stable but it is not resampled.
- ACK without an acceptance: if ce = 0 at the edge leaving ACK, the next state is IDLE.
- Latency: a request accepted at edge E produces ack_o = 1 during the cycle after edge E + WAIT_CYCLES. With WAIT_CYCLES = 0, back-to-back requests give one completion per cycle.
- Memory operation: performed at the edge entering ACK, using the latched request.
  - Write: each lane with sel[i] = 1 is written; other lanes are untouched. data_o is unchanged.
  - Read: data_o is loaded with the full 32-bit word regardless of sel, and holds until the next read completion or reset.
- Error checks (on the latched request):
  - Legal sel values are 0001, 0010, 0100, 1000, 0011, 1100 and 1111.
  - sel = 0011 or 1100 requires addr[0] = 0. sel = 1111 requires addr[1:0] = 00.
  - Any address bit above DEPTH_LOG2+1 set means out of range.
  - On error: no memory write, data_o forced to 0, ack_o = 1 and err_o = 1 for that ACK cycle.
- Output timing: ack_o and err_o are registered. Both are 0 in every cycle other than ACK.
- Same-word write then read: a read accepted in the ACK cycle of a write to the same word returns the newly written data. No stale-data hazard is permitted.
- Reset mid-operation: rst in the WAIT state aborts the request with no write and no ack. rst in the ACK state clears ack_o on the next cycle; any request presented in that cycle is dropped.
- Counter width: 4 bits. WAIT_CYCLES > 15 is illegal and must be caught by an elaboration-time check.

Test Plan:
- WAIT_CYCLES = 2: write addr 0x00000010, sel 1111, data 0xDEADBEEF at edge E; then read the same address. Required: busy_o = 1 for 2 cycles, ack_o high in the cycle after E+2, err_o = 0; the read returns data_o = 0xDEADBEEF.
- Byte merge: write 0x11223344 with sel 1111, then write 0x000000AA with sel 0001 to the same word, then read. Required: data_o = 0x112233AA.
- Errors: sel 1111 at addr 0x2, sel 0101 at addr 0x0, and sel 1111 at addr 1 << (DEPTH_LOG2+2). Required for each: ack_o = 1, err_o = 1, data_o = 0, and the addressed word unchanged on re-read.
- WAIT_CYCLES = 0 streaming: hold ce = 1 for 4 cycles with writes to words 0..3, then read them. Required: ack_o high 4 consecutive cycles, busy_o = 0 throughout, and data read back matches.
- Reset in the middle of a WAIT_CYCLES = 3 write: assert rst in the second WAIT cycle. Required: ack_o never pulses, all outputs 0 the cycle after, and the target word retains its old value.
- Write then immediate read of the same word at WAIT_CYCLES = 0: required data_o equals the newly written value in the read's ACK cycle.
